usb_stream_arb: RTL and testbench

- Parametrised successor to the single-channel usbstreamer: merges NUM_CH independent byte streams onto one FT245-style synchronous FIFO write bus.
- Each channel has its own FIFO; a round-robin arbiter drains the channels in framed bursts.
- Every burst is prefixed with a header byte carrying channel id and byte count, so host software can demultiplex.
- Sits between capture sources (ULPI data, debug taps) and the FTDI pins; replaces the fixed-byte streamer in test tops.

---
 rtl/usb_stream_arb_if.sv | 23 ++
 rtl/usb_stream_arb.sv | 180 ++++++++++++++++++
 tb/tb_usb_stream_arb.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_stream_arb_if.sv
// Bus bundle for usb_stream_arb: per-channel byte inputs on one side,
// FT245-style synchronous FIFO write pins on the other.
interface usb_stream_arb_if #(
    parameter int NUM_CH = 4
);
    logic [8*NUM_CH-1:0] IN_DATA;
    logic [NUM_CH-1:0]   IN_WR;
    logic [NUM_CH-1:0]   IN_HAVE_SPACE;
    logic [NUM_CH-1:0]   OVERFLOW;
    logic                USB_TXE_N;
    logic                USB_WR_N;
    logic [7:0]          USB_D;

    modport master (
        output IN_DATA, IN_WR, USB_TXE_N,
        input  IN_HAVE_SPACE, OVERFLOW, USB_WR_N, USB_D
    );

    modport slave (
        input  IN_DATA, IN_WR, USB_TXE_N,
        output IN_HAVE_SPACE, OVERFLOW, USB_WR_N, USB_D
    );
endinterface

// File: rtl/usb_stream_arb.sv
// Merges NUM_CH byte streams onto one FT245 write bus as framed bursts:
// header {ch[2:0], len[4:0]} followed by len payload bytes, round-robin.
module usb_stream_arb #(
    parameter int NUM_CH    = 4,
    parameter int FIFO_AW   = 5,
    parameter int BURST_MAX = 16
) (
    input  logic             CLK,
    input  logic             RST,
    usb_stream_arb_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    logic [7:0]         mem_r    [NUM_CH][DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r [NUM_CH];
    logic [FIFO_AW-1:0] rd_ptr_r [NUM_CH];
    logic [FIFO_AW:0]   count_r  [NUM_CH];
    logic [NUM_CH-1:0]  full_s, push_s, pop_s, overflow_r;

    state_t            state_r, state_s;
    logic [CH_W-1:0]   ch_r, ch_s, rr_ptr_r, rr_ptr_s, sel_s;
    logic [4:0]        len_r, len_s, rem_r, rem_s, sel_len_s;
    logic [FIFO_AW:0]  sel_cnt_s;
    logic              found_s, wr_n_r, wr_n_s, xfer_s;
    logic [7:0]        d_r, d_s, head_byte_s;

    // Full flags use the pre-pop count, so a write into a full FIFO is dropped even on a pop cycle
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            full_s[n] = (count_r[n] == FULL_CNT);
            push_s[n] = bus.IN_WR[n] & ~full_s[n];
        end
    end

    assign bus.IN_HAVE_SPACE = ~full_s;
    assign bus.OVERFLOW      = overflow_r;
    assign bus.USB_WR_N      = wr_n_r;
    assign bus.USB_D         = d_r;
    assign xfer_s            = ~wr_n_r & ~bus.USB_TXE_N;

    // Round-robin search starting just after the last served channel
    always_comb begin
        int idx;
        found_s = 1'b0;
        sel_s   = CH_W'(0);
        idx     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            if (!found_s && (count_r[idx] != (FIFO_AW+1)'(0))) begin
                found_s = 1'b1;
                sel_s   = CH_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
        sel_cnt_s = count_r[sel_s];
        if (int'(sel_cnt_s) > BURST_MAX) begin
            sel_len_s = 5'(BURST_MAX);
        end else begin
            sel_len_s = 5'(sel_cnt_s);
        end
        head_byte_s = {3'(sel_s), sel_len_s};
    end

    // Burst FSM next-state and output/pop decode
    always_comb begin
        state_s  = state_r;
        ch_s     = ch_r;
        len_s    = len_r;
        rem_s    = rem_r;
        rr_ptr_s = rr_ptr_r;
        wr_n_s   = wr_n_r;
        d_s      = d_r;
        pop_s    = {NUM_CH{1'b0}};
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    ch_s     = sel_s;
                    len_s    = sel_len_s;
                    d_s      = head_byte_s;
                    wr_n_s   = 1'b0;
                    rr_ptr_s = sel_s;
                    state_s  = HEADER;
                end else begin
                    wr_n_s   = 1'b1;
                end
            end
            HEADER: begin
                if (xfer_s) begin
                    pop_s[ch_r] = 1'b1;
                    d_s         = mem_r[ch_r][rd_ptr_r[ch_r]];
                    rem_s       = len_r - 5'd1;
                    state_s     = DATA;
                end else begin
                    state_s     = HEADER;
                end
            end
            DATA: begin
                if (xfer_s && (rem_r != 5'd0)) begin
                    pop_s[ch_r] = 1'b1;
                    d_s         = mem_r[ch_r][rd_ptr_r[ch_r]];
                    rem_s       = rem_r - 5'd1;
                end else if (xfer_s) begin
                    wr_n_s      = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s     = DATA;
                end
            end
            default: begin
                wr_n_s  = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state and registered FTDI outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            ch_r     <= CH_W'(0);
            len_r    <= 5'd0;
            rem_r    <= 5'd0;
            rr_ptr_r <= CH_W'(NUM_CH - 1);
            wr_n_r   <= 1'b1;
            d_r      <= 8'd0;
        end else begin
            state_r  <= state_s;
            ch_r     <= ch_s;
            len_r    <= len_s;
            rem_r    <= rem_s;
            rr_ptr_r <= rr_ptr_s;
            wr_n_r   <= wr_n_s;
            d_r      <= d_s;
        end
    end

    // Per-channel FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < NUM_CH; n++) begin
                wr_ptr_r[n] <= FIFO_AW'(0);
                rd_ptr_r[n] <= FIFO_AW'(0);
                count_r[n]  <= (FIFO_AW+1)'(0);
            end
            overflow_r <= {NUM_CH{1'b0}};
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (push_s[n]) wr_ptr_r[n] <= wr_ptr_r[n] + FIFO_AW'(1);
                if (pop_s[n])  rd_ptr_r[n] <= rd_ptr_r[n] + FIFO_AW'(1);
                case ({push_s[n], pop_s[n]})
                    2'b10:   count_r[n] <= count_r[n] + (FIFO_AW+1)'(1);
                    2'b01:   count_r[n] <= count_r[n] - (FIFO_AW+1)'(1);
                    default: count_r[n] <= count_r[n];
                endcase
                overflow_r[n] <= overflow_r[n] | (bus.IN_WR[n] & full_s[n]);
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge CLK) begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (push_s[n]) mem_r[n][wr_ptr_r[n]] <= bus.IN_DATA[8*n +: 8];
        end
    end
endmodule

// File: tb/tb_usb_stream_arb.sv
// Bench for usb_stream_arb: queue-based reference model feeds an expected-byte
// scoreboard; a negedge monitor compares every presented byte and status flag.
module tb_usb_stream_arb;
    localparam int NUM_CH    = 4;
    localparam int FIFO_AW   = 5;
    localparam int BURST_MAX = 16;
    localparam int DEPTH     = 1 << FIFO_AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_stream_arb_if #(.NUM_CH(NUM_CH)) bus();

    usb_stream_arb #(.NUM_CH(NUM_CH), .FIFO_AW(FIFO_AW), .BURST_MAX(BURST_MAX)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct { logic [7:0] b; bit hdr; } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] chq[NUM_CH][$];
    logic [7:0] seen_hdr[$];
    int         occ[NUM_CH];
    bit         ovf[NUM_CH];
    int         outstanding;
    int         cur_ch;
    int         rr;

    task automatic check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: channel queues, occupancy counts and a burst byte budget
    always @(posedge clk) begin : model
        bit full_pre[NUM_CH];
        bit x;
        int c, len;
        logic [7:0] v;
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                chq[n].delete();
                occ[n] = 0;
                ovf[n] = 1'b0;
            end
            exp_q.delete();
            outstanding = 0;
            rr = NUM_CH - 1;
        end else begin
            for (int n = 0; n < NUM_CH; n++) full_pre[n] = (occ[n] == DEPTH);
            x = (outstanding != 0) && !bus.USB_TXE_N;
            if (outstanding == 0) begin
                c = -1;
                for (int i = 1; i <= NUM_CH; i++)
                    if (c < 0 && occ[(rr + i) % NUM_CH] != 0) c = (rr + i) % NUM_CH;
                if (c >= 0) begin
                    len = (occ[c] < BURST_MAX) ? occ[c] : BURST_MAX;
                    exp_q.push_back('{b: 8'(c * 32 + len), hdr: 1'b1});
                    for (int k = 0; k < len; k++) begin
                        v = chq[c].pop_front();
                        exp_q.push_back('{b: v, hdr: 1'b0});
                    end
                    outstanding = len + 1;
                    cur_ch = c;
                    rr = c;
                end
            end else if (x) begin
                if (outstanding >= 2) occ[cur_ch]--;
                outstanding--;
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (bus.IN_WR[n]) begin
                    if (full_pre[n]) ovf[n] = 1'b1;
                    else begin
                        chq[n].push_back(bus.IN_DATA[8*n +: 8]);
                        occ[n]++;
                    end
                end
            end
        end
    end

    // Monitor: status flags every cycle, payload against scoreboard while USB_WR_N is low
    always @(negedge clk) begin : monitor
        int sp, ov;
        if (!rst) begin
            sp = 0;
            ov = 0;
            for (int n = 0; n < NUM_CH; n++) begin
                if (occ[n] != DEPTH) sp = sp | (1 << n);
                if (ovf[n]) ov = ov | (1 << n);
            end
            check("usb_wr_n", int'(bus.USB_WR_N), int'(outstanding == 0));
            check("in_have_space", int'(bus.IN_HAVE_SPACE), sp);
            check("overflow", int'(bus.OVERFLOW), ov);
            if (!bus.USB_WR_N) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL usb_d: byte 0x%0h presented, expected no byte", bus.USB_D);
                end else begin
                    check("usb_d", int'(bus.USB_D), int'(exp_q[0].b));
                    if (!bus.USB_TXE_N) begin
                        if (exp_q[0].hdr) seen_hdr.push_back(exp_q[0].b);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int ch, int val);
        bus.IN_DATA[8*ch +: 8] = 8'(val);
        bus.IN_WR[ch] = 1'b1;
    endtask

    task automatic wait_hdrs(string name, int n, int budget);
        int c = 0;
        while (seen_hdr.size() < n && c < budget) begin
            tick();
            c++;
        end
        check({name, "_timeout"}, int'(seen_hdr.size() >= n), 1);
    endtask

    task automatic wait_drain(string name, int budget);
        int c = 0;
        int busy = 1;
        while (busy != 0 && c < budget) begin
            busy = exp_q.size() + outstanding;
            for (int n = 0; n < NUM_CH; n++) busy += occ[n];
            if (busy != 0) begin
                tick();
                c++;
            end
        end
        check({name, "_drain_timeout"}, busy, 0);
    endtask

    task automatic check_hdrs(string name, int n, logic [63:0] expv);
        int got;
        check({name, "_hdr_count"}, seen_hdr.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < seen_hdr.size()) ? int'(seen_hdr[i]) : -1;
            check({name, "_hdr"}, got, int'(expv[8*i +: 8]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.IN_DATA = '0;
        bus.IN_WR = '0;
        bus.USB_TXE_N = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_wr_n", int'(bus.USB_WR_N), 1);
        check("reset_usb_d", int'(bus.USB_D), 0);
        check("reset_space", int'(bus.IN_HAVE_SPACE), 15);
        check("reset_overflow", int'(bus.OVERFLOW), 0);

        // Latency: strobe driven after edge k, header visible after edge k+2
        bus.USB_TXE_N = 1'b0;
        put(0, 8'h55);
        tick();
        bus.IN_WR = '0;
        tick();
        check("latency_wr_n", int'(bus.USB_WR_N), 0);
        check("latency_header", int'(bus.USB_D), 8'h01);
        wait_drain("latency", 50);

        // ch3 burst parks the FSM while ch0 (3 bytes) and ch1 (20 bytes) fill up
        seen_hdr.delete();
        bus.USB_TXE_N = 1'b1;
        put(3, 8'hEE);
        tick();
        bus.IN_WR = '0;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i < 3) put(0, 8'hA1 + i);
            put(1, i);
            tick();
            bus.IN_WR = '0;
        end
        bus.USB_TXE_N = 1'b0;
        wait_hdrs("split", 3, 100);
        repeat (4) tick();
        bus.USB_TXE_N = 1'b1;
        repeat (5) tick();
        bus.USB_TXE_N = 1'b0;
        wait_drain("split", 200);
        check_hdrs("split", 4, 64'h24_30_03_61);

        // Fairness: a just-served channel waits behind ch0
        seen_hdr.delete();
        bus.USB_TXE_N = 1'b1;
        put(3, 8'h77);
        tick();
        bus.IN_WR = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            put(0, 8'h10 + i);
            put(2, 8'h20 + i);
            put(3, 8'h30 + i);
            tick();
            bus.IN_WR = '0;
        end
        bus.USB_TXE_N = 1'b0;
        wait_hdrs("fair", 4, 100);
        bus.USB_TXE_N = 1'b1;
        put(3, 8'h99);
        tick();
        bus.IN_WR = '0;
        put(0, 8'h88);
        tick();
        bus.IN_WR = '0;
        bus.USB_TXE_N = 1'b0;
        wait_drain("fair", 100);
        check_hdrs("fair", 6, 64'h61_01_62_42_02_61);

        // Overflow: ch2 gets 33 writes while the bus is stalled behind a ch1 header
        seen_hdr.delete();
        bus.USB_TXE_N = 1'b1;
        put(1, 8'hC3);
        tick();
        bus.IN_WR = '0;
        tick();
        for (int i = 0; i < 33; i++) begin
            put(2, 8'h40 + i);
            tick();
            bus.IN_WR = '0;
            if (i == 31) begin
                check("full_space2", int'(bus.IN_HAVE_SPACE[2]), 0);
                check("full_no_ovf2", int'(bus.OVERFLOW[2]), 0);
            end
        end
        check("ovf2_set", int'(bus.OVERFLOW[2]), 1);
        tick();
        bus.USB_TXE_N = 1'b0;
        wait_drain("ovf", 200);
        check_hdrs("ovf", 3, 64'h50_50_21);
        check("ovf2_sticky", int'(bus.OVERFLOW[2]), 1);

        // Random traffic against the model
        for (int t = 0; t < 1500; t++) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if ($urandom_range(0, 3) == 0) put(n, $urandom_range(0, 255));
            end
            bus.USB_TXE_N = ($urandom_range(0, 9) < 3);
            tick();
            bus.IN_WR = '0;
        end
        bus.USB_TXE_N = 1'b0;
        wait_drain("random", 2000);

        // Reset in the middle of a 10-byte ch0 burst
        seen_hdr.delete();
        bus.USB_TXE_N = 1'b1;
        put(1, 8'h5C);
        tick();
        bus.IN_WR = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            put(0, 8'hD0 + i);
            tick();
            bus.IN_WR = '0;
        end
        bus.USB_TXE_N = 1'b0;
        wait_hdrs("midrst", 2, 50);
        check("midrst_hdr", int'(seen_hdr[seen_hdr.size() - 1]), 8'h0A);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_wr_n", int'(bus.USB_WR_N), 1);
        check("midrst_space", int'(bus.IN_HAVE_SPACE), 15);
        check("midrst_overflow", int'(bus.OVERFLOW), 0);
        rst = 1'b0;
        seen_hdr.delete();
        tick();
        put(0, 8'h5A);
        tick();
        bus.IN_WR = '0;
        wait_drain("postrst", 50);
        check_hdrs("postrst", 1, 64'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
